// File: rtl/seq_subtractor.sv
// Chunk-serial subtractor: diff = a - b - bin, CHUNK bits per clock, borrow carried between chunks.
// Optional signed-overflow flag enabled by defining SUB_OVF_FLAG_EN; otherwise ovf is tied to 0.
`ifndef N
`define N 8
`endif

module seq_subtractor #(
    parameter int WIDTH = `N,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic [31:0]      base_s;
    logic [CHUNK-1:0] a_k_s, b_k_s, g_s, p_s, d_k_s;
    logic [CHUNK:0]   bor_s;
    logic             term_s;
    logic [WIDTH-1:0] mask_s;

    // Select the active chunk and resolve its borrows as a flat sum of products.
    always_comb begin
        base_s = 32'(cnt_q) * 32'(CHUNK);
        a_k_s  = CHUNK'(a_q >> base_s);
        b_k_s  = CHUNK'(b_q >> base_s);
        g_s    = ~a_k_s & b_k_s;
        p_s    = ~(a_k_s ^ b_k_s);
        bor_s  = {(CHUNK+1){1'b0}};
        term_s = 1'b0;
        bor_s[0] = brw_q;
        for (int i = 1; i <= CHUNK; i++) begin
            term_s = brw_q;
            for (int j = 0; j < i; j++) begin
                term_s = term_s & p_s[j];
            end
            bor_s[i] = term_s;
            for (int j = 0; j < i; j++) begin
                term_s = g_s[j];
                for (int k = j + 1; k < i; k++) begin
                    term_s = term_s & p_s[k];
                end
                bor_s[i] = bor_s[i] | term_s;
            end
        end
        d_k_s  = a_k_s ^ b_k_s ^ bor_s[CHUNK-1:0];
        mask_s = WIDTH'({CHUNK{1'b1}}) << base_s;
    end

`ifdef SUB_OVF_FLAG_EN
    logic ovf_q, ovf_d;
`endif

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                diff_d = (diff_q & ~mask_s) | ((WIDTH'(d_k_s) << base_s) & mask_s);
                brw_d  = bor_s[CHUNK];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    bout_d  = bor_s[CHUNK];
`ifdef SUB_OVF_FLAG_EN
                    ovf_d   = bor_s[CHUNK-1] ^ bor_s[CHUNK];
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            brw_q   <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SUB_OVF_FLAG_EN
    // Overflow flag register, loaded on the last RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: directed cases plus random operands against an arithmetic model.
module tb_seq_subtractor;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int NCH = W / CH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    seq_subtractor #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands, unsigned and signed views.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi,
                                  output logic [W-1:0] md, output logic mbo, output logic mov);
        int r;
        int s;
        r   = int'(ma) - int'(mb) - int'(mbi);
        s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbi);
        md  = r[W-1:0];
        mbo = (r < 0);
`ifdef SUB_OVF_FLAG_EN
        mov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
`else
        mov = 1'b0;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbi, input int hold);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           lat;
        model(ta, tbv, tbi, ed, eb, eo);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = ta; b = tbv; bin = tbi; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        check("in_ready_run", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NCH);
        check("diff", diff, ed);
        check("bout", bout, eb);
        check("ovf", ovf, eo);
        check("in_ready_done", in_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_diff", diff, ed);
            check("hold_bout", bout, eb);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h23, 1'b0, 0);
        run_op(8'h10, 8'h20, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'h00, 1'b1, 0);
        run_op(8'h7F, 8'hFF, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        run_op(8'hC3, 8'h3C, 1'b1, 5);

        // Reset during the first RUN cycle.
        @(negedge clk);
        a = 8'hAA; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_diff", diff, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", in_ready, 1);
        check("postrst_out_valid", out_valid, 0);
        run_op(8'h01, 8'h01, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
